// File: rtl/serial_parallel_sync_ctrl_if.sv
// Serial receive lane bundle: pin-sampler bit/realign in, framed byte stream and sync status out.
// master = the side that drives the serial bit; slave = the framing controller.
interface serial_parallel_sync_ctrl_if;
    logic       Data_in;
    logic       realign;
    logic [7:0] Data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;
    logic [1:0] state;

    modport master (
        output Data_in, realign,
        input  Data_out, valid_out, byte_strobe, active, state
    );

    modport slave (
        input  Data_in, realign,
        output Data_out, valid_out, byte_strobe, active, state
    );
endinterface

// File: rtl/serial_parallel_sync_ctrl.sv
// Comma hunt / byte-phase lock for the serial receive lane; emits qualified parallel bytes once locked.
// All outputs registered, updated on the deciding edge; no backpressure (free-running bit clock).
module serial_parallel_sync_ctrl #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter logic [7:0] IDLE       = 8'h7C,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 16
) (
    input  logic                         clk_32f,
    input  logic                         reset,
    serial_parallel_sync_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e     state_q;
    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] comma_cnt_q;
    logic [7:0] gap_cnt_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       strobe_q;

    // Byte completing at this edge, including the bit being sampled now.
    logic [7:0] win;
    logic       boundary;
    assign win      = {sr_q[6:0], bus.Data_in};
    assign boundary = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            sr_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 4'd0;
            gap_cnt_q   <= 8'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            sr_q     <= win;
            strobe_q <= 1'b0;
            if (bus.realign) begin
                state_q     <= SEARCH;
                bit_cnt_q   <= 3'd0;
                comma_cnt_q <= 4'd0;
                gap_cnt_q   <= 8'd0;
                valid_q     <= 1'b0;
            end else begin
                case (state_q)
                    SEARCH: begin
                        if (win == COMMA) begin
                            bit_cnt_q   <= 3'd0;
                            comma_cnt_q <= 4'd1;
                            state_q     <= ALIGN;
                        end
                    end
                    ALIGN: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (boundary) begin
                            if (win != COMMA) begin
                                state_q     <= SEARCH;
                                comma_cnt_q <= 4'd0;
                            end else if (comma_cnt_q == 4'(LOCK_COUNT - 1)) begin
                                state_q   <= LOCKED;
                                gap_cnt_q <= 8'd0;
                            end else begin
                                comma_cnt_q <= comma_cnt_q + 4'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (boundary) begin
                            if (win == COMMA || win == IDLE) begin
                                strobe_q  <= 1'b1;
                                data_q    <= win;
                                valid_q   <= 1'b0;
                                gap_cnt_q <= 8'd0;
                            end else if (gap_cnt_q < 8'(MAX_GAP)) begin
                                strobe_q  <= 1'b1;
                                data_q    <= win;
                                valid_q   <= 1'b1;
                                gap_cnt_q <= gap_cnt_q + 8'd1;
                            end else begin
                                // Too long without a comma/idle: treat as lost framing, re-hunt.
                                state_q     <= SEARCH;
                                valid_q     <= 1'b0;
                                bit_cnt_q   <= 3'd0;
                                comma_cnt_q <= 4'd0;
                                gap_cnt_q   <= 8'd0;
                            end
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign bus.Data_out    = data_q;
    assign bus.valid_out   = valid_q;
    assign bus.byte_strobe = strobe_q;
    assign bus.active      = (state_q == LOCKED);
    assign bus.state       = state_q;

endmodule

// File: tb/tb_serial_parallel_sync_ctrl.sv
// Directed-vector bench for the serial framing controller: lock, filtering, watchdog, realign, reset.
module tb_serial_parallel_sync_ctrl;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;

    serial_parallel_sync_ctrl_if bus ();

    serial_parallel_sync_ctrl dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk_32f = ~clk_32f;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send the low n bits of v, MSB first, one bit per rising edge; returns #1 after the last edge.
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk_32f);
            bus.Data_in = v[i];
            @(posedge clk_32f);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits({24'h0, b}, 8);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                           input logic s, input logic [1:0] st);
        chk({tag, ".data"},   {24'h0, bus.Data_out},    {24'h0, d});
        chk({tag, ".valid"},  {31'h0, bus.valid_out},   {31'h0, v});
        chk({tag, ".strobe"}, {31'h0, bus.byte_strobe}, {31'h0, s});
        chk({tag, ".state"},  {30'h0, bus.state},       {30'h0, st});
        chk({tag, ".active"}, {31'h0, bus.active},      {31'h0, (st == 2'd2)});
    endtask

    initial begin
        bus.Data_in = 1'b0;
        bus.realign = 1'b0;
        #1 reset = 1'b1;
        #1 chk_out("reset", 8'h00, 1'b0, 1'b0, 2'd0);
        @(negedge clk_32f);
        reset = 1'b0;

        // Lock: state 0->1 on first comma, 1->2 at the fourth.
        send_byte(8'hBC);
        chk_out("lock.c1", 8'h00, 1'b0, 1'b0, 2'd1);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_bits(32'h5E, 7);
        chk("lock.pre_state", {30'h0, bus.state}, 32'd1);
        send_bits(32'h0, 1);
        chk_out("lock.c4", 8'h00, 1'b0, 1'b0, 2'd2);
        send_byte(8'hFF);
        chk_out("lock.ff", 8'hFF, 1'b1, 1'b1, 2'd2);
        send_bits(32'h1, 1);
        chk_out("lock.pulse_end", 8'hFF, 1'b1, 1'b0, 2'd2);
        send_bits(32'h6E, 7);
        chk_out("filt.ee", 8'hEE, 1'b1, 1'b1, 2'd2);

        // Filtering: COMMA and IDLE strobe but are not valid.
        send_byte(8'hAA);
        chk_out("filt.aa", 8'hAA, 1'b1, 1'b1, 2'd2);
        send_byte(8'hBC);
        chk_out("filt.bc", 8'hBC, 1'b0, 1'b1, 2'd2);
        send_byte(8'hCC);
        chk_out("filt.cc", 8'hCC, 1'b1, 1'b1, 2'd2);
        send_byte(8'h7C);
        chk_out("filt.7c", 8'h7C, 1'b0, 1'b1, 2'd2);

        // Watchdog: 16 data bytes accepted, the 17th drops framing.
        for (int i = 0; i < 16; i++) send_byte(8'h11);
        chk_out("wd.16", 8'h11, 1'b1, 1'b1, 2'd2);
        send_byte(8'h11);
        chk_out("wd.17", 8'h11, 1'b0, 1'b0, 2'd0);

        // Lock failure then relock.
        send_byte(8'hBC);
        chk("fail.c1_state", {30'h0, bus.state}, 32'd1);
        send_byte(8'hBC);
        chk("fail.c2_state", {30'h0, bus.state}, 32'd1);
        send_byte(8'h55);
        chk_out("fail.55", 8'h11, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        chk("relock.state", {30'h0, bus.state}, 32'd2);
        send_byte(8'h5A);
        chk_out("relock.5a", 8'h5A, 1'b1, 1'b1, 2'd2);

        // Realign mid-byte.
        send_bits(32'h2, 3);
        bus.realign = 1'b1;
        send_bits(32'h0, 1);
        bus.realign = 1'b0;
        chk_out("realign", 8'h5A, 1'b0, 1'b0, 2'd0);
        send_bits(32'h0, 4);

        // Bit slip: 3 junk bits then commas at a new phase.
        send_bits(32'h5, 3);
        send_byte(8'hBC);
        chk("slip.c1_state", {30'h0, bus.state}, 32'd1);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        chk("slip.lock", {30'h0, bus.state}, 32'd2);
        send_byte(8'hFF);
        chk_out("slip.ff", 8'hFF, 1'b1, 1'b1, 2'd2);

        // Asynchronous reset mid-byte, checked before any clock edge.
        send_bits(32'h3, 3);
        @(negedge clk_32f);
        #2 reset = 1'b1;
        #1 chk_out("areset", 8'h00, 1'b0, 1'b0, 2'd0);
        @(negedge clk_32f);
        reset = 1'b0;
        send_byte(8'h00);
        chk_out("post_reset", 8'h00, 1'b0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_parallel_sync_ctrl.md
Name: serial_parallel_sync_ctrl

Overview:
Framing and alignment controller for the serial-to-parallel receive lane, running on clk_32f.
- Hunts the serial bit stream for the COMMA character (0xBC) and locks byte phase after LOCK_COUNT consecutive aligned commas.
- Then emits parallel bytes with valid qualification: COMMA and IDLE (0x7C) bytes are marked invalid.
- Sits between the serial pin sampler and the parallel-side consumers; owns lane sync state and loss-of-framing recovery.

Parameters:
COMMA, 8'hBC, alignment character, MSB first on the line
IDLE, 8'h7C, filler character, never marked valid
LOCK_COUNT, 4, consecutive aligned commas needed to lock; legal range 2..15
MAX_GAP, 16, max consecutive data bytes allowed in LOCKED without a COMMA or IDLE; legal range 1..255

Ports:
clk_32f  input  1  bit clock; one serial bit sampled per rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
Data_in  input  1  serial data, MSB of each byte first
realign  input  1  synchronous request to drop lock and re-hunt
Data_out  output  8  last byte captured in LOCKED
valid_out  output  1  Data_out holds a data byte (not COMMA/IDLE)
byte_strobe  output  1  one-cycle pulse each time Data_out/valid_out update
active  output  1  lane locked (state==LOCKED)
state  output  2  0=SEARCH, 1=ALIGN, 2=LOCKED

Behaviour:
- Reset values (all registers): sr=0, bit_cnt=0, comma_cnt=0, gap_cnt=0, state=SEARCH, Data_out=0, valid_out=0, byte_strobe=0, active=0.
- sr is an 8-bit shift register, sr <= {sr[6:0], Data_in} every edge. Window w = {sr[6:0], Data_in} (combinational) is the byte completing at this edge.
- All outputs are registered; they change on the edge where the decision is made.
- SEARCH:
  - Each edge, if w==COMMA: bit_cnt<=0, comma_cnt<=1, state<=ALIGN. Otherwise stay.
  - valid_out=0, byte_strobe=0, active=0.
- ALIGN:
  - bit_cnt increments mod 8 every edge. A byte boundary is any edge with bit_cnt==7, i.e. exactly 8 edges after the previous boundary or match.
  - At a boundary, w==COMMA and comma_cnt==LOCK_COUNT-1: state<=LOCKED, active<=1, gap_cnt<=0.
  - At a boundary, w==COMMA otherwise: comma_cnt++.
  - At a boundary, w!=COMMA: state<=SEARCH, comma_cnt<=0.
  - No outputs strobe in ALIGN.
- LOCKED, at each boundary:
  - byte_strobe<=1 for one cycle; Data_out<=w.
  - w==COMMA or w==IDLE: valid_out<=0, gap_cnt<=0.
  - Data byte with gap_cnt<MAX_GAP: valid_out<=1, gap_cnt++.
  - Data byte with gap_cnt==MAX_GAP: framing loss. No strobe; Data_out holds; valid_out<=0, active<=0, state<=SEARCH, counters cleared.
- LOCKED, between boundaries: Data_out and valid_out hold, byte_strobe=0.
- Lock requires 1 matching comma plus LOCK_COUNT-1 boundary commas. Latency from the edge completing the first comma to active=1 is (LOCK_COUNT-1)*8 edges. The locking comma itself is not strobed.
- realign=1 at an edge (any state): state<=SEARCH, counters cleared, valid_out<=0, active<=0, byte_strobe<=0. That edge's w is not evaluated for a match; sr still shifts. realign beats all other transitions.
- A misaligned COMMA pattern inside LOCKED data (non-boundary) is ignored; alignment changes only via SEARCH.
- Asynchronous reset mid-byte aborts immediately. After deassertion, the first possible match is 8 edges later, since sr starts at 0.
- state output reflects the state register; active == (state==LOCKED) at all times.

Test Plan:
- Lock: reset, then 4x 0xBC, then 0xFF -> state 0->1 at first comma edge t0, 1->2 at t0+24; at t0+32 Data_out=0xFF, valid_out=1, byte_strobe=1 for one cycle.
- Filtering: locked, then 0xEE, 0xAA, 0xBC, 0xCC, 0x7C -> strobes at each boundary; valid_out=1,1,0,1,0; Data_out follows each byte.
- Lock failure: 0xBC, 0xBC, 0x55 -> ALIGN then SEARCH at the 0x55 boundary; active never 1; a following 4x 0xBC locks normally.
- Bit-slip hunt: 3 junk bits (1,0,1), then 4x 0xBC -> lock at correct phase; next 0xFF appears intact on Data_out.
- Watchdog (MAX_GAP=16): locked, 17 consecutive 0x11 -> 16 valid strobes; on the 17th boundary no strobe, valid_out=0, state=SEARCH, active=0.
- Control: realign pulsed mid-byte while locked -> next edge state=SEARCH, valid_out=0, active=0. Reset asserted mid-byte -> all outputs 0 immediately, without a clock edge.
